// File: rtl/ioctl_mem_loader.sv
// ioctl_mem_loader: packs ioctl download bytes into 16-bit LE words
// and writes them to memory; optional IOCTL_MEM_LOADER_CHECKSUM_EN.
module ioctl_mem_loader #(
  parameter logic [24:0] BASE_ADDR  = 25'h0000000,
  parameter logic [7:0]  INDEX      = 8'h00,
  parameter logic [7:0]  INDEX_MASK = 8'h3F,
  parameter int          FIFO_AW    = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        clkref_n,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        busy,
  output logic        load_done,
  output logic        overflow,
  output logic [31:0] byte_count
`ifdef IOCTL_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] TWO = (FIFO_AW+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic dl_q;
  logic pend_q, pend_d;
  logic hold_v_q, hold_v_d;
  logic [7:0] hold_b_q, hold_b_d;
  logic [25:0] hold_a_q, hold_a_d;
  logic stash_v_q, stash_v_d;
  logic [42:0] stash_q, stash_d;
  logic [FIFO_AW-1:0] wp_q, wp_d;
  logic [FIFO_AW-1:0] rp_q, rp_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [FIFO_AW:0] free_d;
  logic clkref_q, clkref_d;
  logic ovf_q, ovf_d;
  logic [31:0] bc_q, bc_d;
  logic [42:0] fifo_q [DEPTH];
  logic [42:0] head;
  logic [42:0] push_e;
  logic [25:0] wa;
  logic match, rise, pop, room, push, acc, enter;

  assign match = (ioctl_index & INDEX_MASK) == (INDEX & INDEX_MASK);
  assign rise = ioctl_download & ~dl_q;
  assign wa = ioctl_addr[26:1];
  assign pop = (cnt_q != '0) && mem_ack;
  assign room = (cnt_q != FULL_CNT) || pop;
  assign head = fifo_q[rp_q];

  assign mem_req = cnt_q != '0;
  assign mem_addr = mem_req ? BASE_ADDR + head[42:18] : '0;
  assign mem_din = mem_req ? head[17:2] : '0;
  assign mem_be = mem_req ? head[1:0] : '0;
  assign busy = state_q != S_IDLE;
  assign load_done = state_q == S_DONE;
  assign clkref_n = clkref_q;
  assign overflow = ovf_q;
  assign byte_count = bc_q;

  // Next-state, byte packing and FIFO push/pop bookkeeping
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    hold_v_d = hold_v_q;
    hold_b_d = hold_b_q;
    hold_a_d = hold_a_q;
    stash_v_d = stash_v_q;
    stash_d = stash_q;
    ovf_d = ovf_q;
    bc_d = bc_q;
    push = 1'b0;
    push_e = '0;
    acc = 1'b0;
    enter = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (match && ioctl_download && (rise || pend_q)) begin
          state_d = S_LOAD;
          enter = 1'b1;
          ovf_d = 1'b0;
          bc_d = '0;
          hold_v_d = 1'b0;
          stash_v_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (stash_v_q) begin
          // second half of a split displacement; clkref_n is high now
          if (room) begin
            push = 1'b1;
            push_e = stash_q;
            stash_v_d = 1'b0;
          end
          if (ioctl_wr) ovf_d = 1'b1;
        end else if (ioctl_wr) begin
          if (!room) begin
            ovf_d = 1'b1;
          end else begin
            acc = 1'b1;
            bc_d = bc_q + 32'd1;
            if (!ioctl_addr[0]) begin
              if (hold_v_q) begin
                push = 1'b1;
                push_e = {hold_a_q[24:0], 8'h00, hold_b_q, 2'b01};
              end
              hold_v_d = 1'b1;
              hold_b_d = ioctl_dout;
              hold_a_d = wa;
            end else if (hold_v_q && hold_a_q == wa) begin
              push = 1'b1;
              push_e = {wa[24:0], ioctl_dout, hold_b_q, 2'b11};
              hold_v_d = 1'b0;
            end else if (hold_v_q) begin
              push = 1'b1;
              push_e = {hold_a_q[24:0], 8'h00, hold_b_q, 2'b01};
              hold_v_d = 1'b0;
              stash_v_d = 1'b1;
              stash_d = {wa[24:0], ioctl_dout, 8'h00, 2'b10};
            end else begin
              push = 1'b1;
              push_e = {wa[24:0], ioctl_dout, 8'h00, 2'b10};
            end
          end
        end
        if (!ioctl_download) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (rise) pend_d = 1'b1;
        if (stash_v_q) begin
          if (room) begin
            push = 1'b1;
            push_e = stash_q;
            stash_v_d = 1'b0;
          end
        end else if (hold_v_q && room) begin
          push = 1'b1;
          push_e = {hold_a_q[24:0], 8'h00, hold_b_q, 2'b01};
          hold_v_d = 1'b0;
        end
        if (!stash_v_d && !hold_v_d) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rise) pend_d = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (rise) pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wp_d = wp_q + FIFO_AW'(push);
    rp_d = rp_q + FIFO_AW'(pop);
    cnt_d = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    free_d = FULL_CNT - cnt_d;
    clkref_d = !((state_d == S_IDLE) ||
                 (state_d == S_LOAD && !stash_v_d && free_d >= TWO));
  end

  // Control and pointer registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dl_q <= 1'b0;
      pend_q <= 1'b0;
      hold_v_q <= 1'b0;
      hold_b_q <= '0;
      hold_a_q <= '0;
      stash_v_q <= 1'b0;
      stash_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      clkref_q <= 1'b0;
      ovf_q <= 1'b0;
      bc_q <= '0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      pend_q <= pend_d;
      hold_v_q <= hold_v_d;
      hold_b_q <= hold_b_d;
      hold_a_q <= hold_a_d;
      stash_v_q <= stash_v_d;
      stash_q <= stash_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      clkref_q <= clkref_d;
      ovf_q <= ovf_d;
      bc_q <= bc_d;
    end
  end

  // FIFO storage, entries are {word_addr, data, be}
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wp_q] <= push_e;
  end

`ifdef IOCTL_MEM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running byte sum, restarted on each load entry
  always_comb begin
    csum_d = csum_q;
    if (enter) csum_d = '0;
    else if (acc) csum_d = csum_q + {8'h00, ioctl_dout};
  end

  // Checksum register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  logic unused_sum;
  assign unused_sum = acc ^ enter;
`endif

endmodule

// File: tb/tb_ioctl_mem_loader.sv
// tb_ioctl_mem_loader: directed test of ioctl_mem_loader with
// INDEX=1, BASE_ADDR=25'h100000.
module tb_ioctl_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        clkref_n;
  logic        mem_req;
  logic        mem_ack;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        busy;
  logic        load_done;
  logic        overflow;
  logic [31:0] byte_count;
`ifdef IOCTL_MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [42:0] wq[$];
  int done_cnt = 0;
  int req_seen = 0;
  int hi_seen = 0;
  int busy_seen = 0;
  int stall_err = 0;
  logic stall_q = 1'b0;
  logic [42:0] stall_v = '0;

  ioctl_mem_loader #(
    .BASE_ADDR(25'h100000),
    .INDEX(8'h01),
    .INDEX_MASK(8'h3F),
    .FIFO_AW(2)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .clkref_n(clkref_n),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_be(mem_be),
    .busy(busy),
    .load_done(load_done),
    .overflow(overflow),
    .byte_count(byte_count)
`ifdef IOCTL_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && (!mem_req || {mem_addr, mem_din, mem_be} != stall_v))
        stall_err++;
      if (mem_req && mem_ack) wq.push_back({mem_addr, mem_din, mem_be});
      stall_q = mem_req && !mem_ack;
      stall_v = {mem_addr, mem_din, mem_be};
      if (load_done) done_cnt++;
      if (mem_req) req_seen++;
      if (clkref_n) hi_seen++;
      if (busy) busy_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit force_it);
    int n = 0;
    while (!force_it && clkref_n && n < 100) begin
      cyc(1);
      n++;
    end
    chk("wr_permit", 64'(n < 100), 64'd1);
    ioctl_wr = 1'b1;
    ioctl_addr = 27'(a);
    ioctl_dout = d;
    cyc(1);
    ioctl_wr = 1'b0;
  endtask

  function automatic logic [42:0] ent(input logic [24:0] a,
                                      input logic [15:0] d,
                                      input logic [1:0] be);
    return {a, d, be};
  endfunction

  initial begin
    int n0;
    int d0;
    int r0;
    int h0;
    int b0;
    int s0;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    mem_ack = 1'b0;
    cyc(3);
    chk("rst_clkref", 64'(clkref_n), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_bc", 64'(byte_count), 64'd0);
    reset_n = 1'b1;
    cyc(2);

    // basic six-byte load
    n0 = wq.size();
    d0 = done_cnt;
    ioctl_index = 8'h01;
    mem_ack = 1'b1;
    ioctl_download = 1'b1;
    cyc(1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_clkref", 64'(clkref_n), 64'd0);
    for (int i = 0; i < 6; i++) wr(i, 8'((i + 1) * 8'h11), 1'b0);
    ioctl_download = 1'b0;
    cyc(8);
    chk("t1_nwords", 64'(wq.size() - n0), 64'd3);
    chk("t1_w0", 64'(wq[n0]), 64'(ent(25'h100000, 16'h2211, 2'b11)));
    chk("t1_w1", 64'(wq[n0+1]), 64'(ent(25'h100001, 16'h4433, 2'b11)));
    chk("t1_w2", 64'(wq[n0+2]), 64'(ent(25'h100002, 16'h6655, 2'b11)));
    chk("t1_done", 64'(done_cnt - d0), 64'd1);
    chk("t1_bc", 64'(byte_count), 64'd6);
    chk("t1_idle", 64'(busy), 64'd0);

    // odd length and single-cycle latency
    n0 = wq.size();
    ioctl_download = 1'b1;
    cyc(1);
    wr(0, 8'hAA, 1'b0);
    wr(1, 8'hBB, 1'b0);
    chk("t2_lat_req", 64'(mem_req), 64'd1);
    chk("t2_lat_din", 64'(mem_din), 64'h BBAA);
    chk("t2_lat_be", 64'(mem_be), 64'd3);
    chk("t2_lat_addr", 64'(mem_addr), 64'h100000);
    wr(2, 8'hCC, 1'b0);
    cyc(2);
    chk("t2_held", 64'(mem_req), 64'd0);
    chk("t2_n1", 64'(wq.size() - n0), 64'd1);
    ioctl_download = 1'b0;
    cyc(8);
    chk("t2_n2", 64'(wq.size() - n0), 64'd2);
    chk("t2_w1", 64'(wq[n0+1]), 64'(ent(25'h100001, 16'h00CC, 2'b01)));
    chk("t2_bc", 64'(byte_count), 64'd3);

    // backpressure
    n0 = wq.size();
    s0 = stall_err;
    mem_ack = 1'b0;
    ioctl_download = 1'b1;
    cyc(1);
    for (int i = 0; i < 6; i++) wr(i, 8'(8'h30 + i), 1'b0);
    chk("t3_clkref_hi", 64'(clkref_n), 64'd1);
    chk("t3_req", 64'(mem_req), 64'd1);
    cyc(14);
    chk("t3_stall_din", 64'(mem_din), 64'h3130);
    chk("t3_stall_addr", 64'(mem_addr), 64'h100000);
    chk("t3_ovf", 64'(overflow), 64'd0);
    mem_ack = 1'b1;
    for (int i = 6; i < 10; i++) wr(i, 8'(8'h30 + i), 1'b0);
    ioctl_download = 1'b0;
    cyc(10);
    chk("t3_nwords", 64'(wq.size() - n0), 64'd5);
    for (int k = 0; k < 5; k++)
      chk("t3_word", 64'(wq[n0+k]),
          64'(ent(25'h100000 + 25'(k),
                  {8'(8'h31 + 2 * k), 8'(8'h30 + 2 * k)}, 2'b11)));
    chk("t3_stable", 64'(stall_err - s0), 64'd0);
    chk("t3_ovf_end", 64'(overflow), 64'd0);
    chk("t3_bc", 64'(byte_count), 64'd10);

    // overflow on a full FIFO
    n0 = wq.size();
    mem_ack = 1'b0;
    ioctl_download = 1'b1;
    cyc(1);
    for (int i = 0; i < 6; i++) wr(i, 8'(8'h50 + i), 1'b0);
    wr(6, 8'h56, 1'b1);
    wr(7, 8'h57, 1'b1);
    chk("t7_no_ovf", 64'(overflow), 64'd0);
    wr(8, 8'h58, 1'b1);
    chk("t7_ovf", 64'(overflow), 64'd1);
    chk("t7_bc", 64'(byte_count), 64'd8);
    ioctl_download = 1'b0;
    mem_ack = 1'b1;
    cyc(12);
    chk("t7_nwords", 64'(wq.size() - n0), 64'd4);
    chk("t7_w3", 64'(wq[n0+3]), 64'(ent(25'h100003, 16'h5756, 2'b11)));
    chk("t7_sticky", 64'(overflow), 64'd1);

    // index filter
    r0 = req_seen;
    h0 = hi_seen;
    b0 = busy_seen;
    ioctl_index = 8'h02;
    ioctl_download = 1'b1;
    cyc(2);
    for (int i = 0; i < 4; i++) wr(i, 8'(i), 1'b1);
    ioctl_download = 1'b0;
    cyc(4);
    chk("t4_req", 64'(req_seen - r0), 64'd0);
    chk("t4_clkref", 64'(hi_seen - h0), 64'd0);
    chk("t4_busy", 64'(busy_seen - b0), 64'd0);
    chk("t4_ovf_kept", 64'(overflow), 64'd1);

    // non-sequential addresses
    n0 = wq.size();
    ioctl_index = 8'h41;
    ioctl_download = 1'b1;
    cyc(1);
    chk("t5_ovf_clr", 64'(overflow), 64'd0);
    wr(4, 8'h44, 1'b0);
    wr(9, 8'h99, 1'b0);
    ioctl_download = 1'b0;
    cyc(10);
    chk("t5_nwords", 64'(wq.size() - n0), 64'd2);
    chk("t5_w0", 64'(wq[n0]), 64'(ent(25'h100002, 16'h0044, 2'b01)));
    chk("t5_w1", 64'(wq[n0+1]), 64'(ent(25'h100004, 16'h9900, 2'b10)));
    chk("t5_bc", 64'(byte_count), 64'd2);

    // asynchronous reset during DRAIN
    n0 = wq.size();
    d0 = done_cnt;
    mem_ack = 1'b0;
    ioctl_download = 1'b1;
    cyc(1);
    for (int i = 0; i < 6; i++) wr(i, 8'(8'h70 + i), 1'b0);
    ioctl_download = 1'b0;
    cyc(4);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_req", 64'(mem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_req_now", 64'(mem_req), 64'd0);
    chk("t6_busy_now", 64'(busy), 64'd0);
    chk("t6_clkref", 64'(clkref_n), 64'd0);
    chk("t6_addr", 64'(mem_addr), 64'd0);
    cyc(2);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    cyc(10);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_no_words", 64'(wq.size() - n0), 64'd0);
    chk("t6_req_end", 64'(mem_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
